// File: rtl/lpc_pkg.sv
// ---------------------------------------------------------------------------
// lpc_pkg
//   Constants, state encoding and saturation helper shared by the LPC
//   front-end blocks (autocorr and its MAC datapath).
// ---------------------------------------------------------------------------
package lpc_pkg;

    localparam int N_SAMPLES = 240;  // samples per analysis frame
    localparam int ORDER     = 10;   // LPC order; lags 0..ORDER
    localparam int FRAC      = 16;   // fractional bits of samples and r
    localparam int S_AW      = 8;    // sample address width
    localparam int R_AW      = 11;   // r address width (matches levinson r_rsel)
    localparam int ACC_W     = 72;   // accumulator width, headroom for 256 products
    localparam int WNC_SHIFT = 10;   // white-noise correction adds v/1024

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } autocorr_state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 72'sd2147483647;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -72'sd2147483648;

    // Clamp a wide signed value into the signed 32-bit range.
    function automatic logic [31:0] sat32(input logic signed [ACC_W-1:0] v);
        logic [31:0] r;
        if (v > SAT_MAX) begin
            r = 32'h7FFF_FFFF;
        end else if (v < SAT_MIN) begin
            r = 32'h8000_0000;
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/autocorr_mac.sv
// ---------------------------------------------------------------------------
// autocorr_mac
//   Multiply-accumulate datapath for one autocorrelation lag. Holds the
//   72-bit signed accumulator and presents the scaled, saturated result.
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   clear    in   zero the accumulator at the next edge
//   enable   in   add op_a*op_b at the next edge
//   wnc      in   add acc/1024 conditioning to the result (lag 0 only)
//   op_a     in   32-bit signed sample x[n]
//   op_b     in   32-bit signed sample x[n-k]
//   result   out  sat32((acc >>> FRAC) [+ correction])
// ---------------------------------------------------------------------------
module autocorr_mac
    import lpc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               wnc,
    input  logic signed [31:0] op_a,
    input  logic signed [31:0] op_b,
    output logic        [31:0] result
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [63:0]      prod;
    logic signed [ACC_W-1:0] acc_shr;
    logic signed [ACC_W-1:0] res_v;

    always_comb begin
        // Operands are sign-extended explicitly so the multiply is a true
        // 64-bit signed product.
        prod  = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q + $signed({{(ACC_W-64){prod[63]}}, prod});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        acc_shr = acc_q >>> FRAC;
        // acc_shr occupies at most 56 bits, so the correction cannot wrap.
        res_v   = acc_shr;
        if (wnc) begin
            res_v = acc_shr + (acc_shr >>> WNC_SHIFT);
        end
        result  = sat32(res_v);
    end

endmodule

// File: rtl/autocorr.sv
// ---------------------------------------------------------------------------
// autocorr
//   Computes autocorrelation lags r[0..ORDER] of one frame held in the sample
//   register file and writes them to the r register file read by levinson.
//   Per lag: CLEAR (1 cycle), MAC (N_SAMPLES-k cycles), WRITE (1 cycle);
//   FIN pulses done once all lags are written.
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   start             frame request, accepted only in IDLE
//   ready             1 = idle / r valid (also high in FIN)
//   done              one-cycle pulse after r[ORDER] is written
//   s_rsel0/s_r0      sample port 0, x[n] (combinational read)
//   s_rsel1/s_r1      sample port 1, x[n-k] (combinational read)
//   r_we/r_wsel/r_w   r register file write port
// Configuration
//   AUTOCORR_WNC_EN   when defined, r[0] gets +1/1024 white-noise correction
// ---------------------------------------------------------------------------
module autocorr
    import lpc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            ready,
    output logic            done,
    output logic [S_AW-1:0] s_rsel0,
    input  logic [31:0]     s_r0,
    output logic [S_AW-1:0] s_rsel1,
    input  logic [31:0]     s_r1,
    output logic            r_we,
    output logic [R_AW-1:0] r_wsel,
    output logic [31:0]     r_w
);

    autocorr_state_t state_q, state_d;
    logic [R_AW-1:0] k_q, k_d;
    logic [S_AW-1:0] n_q, n_d;
    logic            mac_clear;
    logic            mac_en;
    logic            wnc;
    logic [31:0]     mac_result;

`ifdef AUTOCORR_WNC_EN
    assign wnc = (k_q == '0);
`else
    assign wnc = 1'b0;
`endif

    autocorr_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (mac_clear),
        .enable (mac_en),
        .wnc    (wnc),
        .op_a   (s_r0),
        .op_b   (s_r1),
        .result (mac_result)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        ready     = 1'b0;
        done      = 1'b0;
        r_we      = 1'b0;
        r_wsel    = '0;
        r_w       = '0;
        s_rsel0   = '0;
        s_rsel1   = '0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    k_d     = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mac_clear = 1'b1;
                n_d       = S_AW'(k_q);   // first product is x[k]*x[0]
                state_d   = MAC;
            end
            MAC: begin
                mac_en  = 1'b1;
                s_rsel0 = n_q;
                s_rsel1 = n_q - S_AW'(k_q);
                n_d     = n_q + 1'b1;
                if (n_q == S_AW'(N_SAMPLES - 1)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                r_we   = 1'b1;
                r_wsel = k_q;
                r_w    = mac_result;
                if (k_q == R_AW'(ORDER)) begin
                    state_d = FIN;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = CLEAR;
                end
            end
            FIN: begin
                // start is deliberately not sampled here; a held start
                // launches the next frame from IDLE.
                ready   = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
        end
    end

endmodule

// File: tb/tb_autocorr.sv
// ---------------------------------------------------------------------------
// tb_autocorr
//   Scoreboard bench: each frame pushes its expected r writes into a queue;
//   an independent monitor pops and compares on every r_we.
// ---------------------------------------------------------------------------
module tb_autocorr;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        ready;
    logic        done;
    logic [7:0]  s_rsel0;
    logic [31:0] s_r0;
    logic [7:0]  s_rsel1;
    logic [31:0] s_r1;
    logic        r_we;
    logic [10:0] r_wsel;
    logic [31:0] r_w;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] samples [0:255];
    int          checks      = 0;
    int          passes      = 0;
    int          write_count = 0;
    int          done_count  = 0;

    assign s_r0 = samples[s_rsel0];
    assign s_r1 = samples[s_rsel1];

    autocorr dut (
        .clk     (clk),
        .reset   (reset_n),
        .start   (start),
        .ready   (ready),
        .done    (done),
        .s_rsel0 (s_rsel0),
        .s_r0    (s_r0),
        .s_rsel1 (s_rsel1),
        .s_r1    (s_r1),
        .r_we    (r_we),
        .r_wsel  (r_wsel),
        .r_w     (r_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every r write against the scoreboard head.
    always @(negedge clk) begin
        wr_t e;
        if (reset_n && r_we) begin
            write_count++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: r[%0d]=0x%08h written, expected no write", r_wsel, r_w);
            end else begin
                e = exp_q.pop_front();
                $display("write r[%0d] = 0x%08h (expected r[%0d] = 0x%08h)", r_wsel, r_w, e.addr, e.data);
                check("r_wsel", 64'(r_wsel), 64'(e.addr));
                check("r_w", 64'(r_w), 64'(e.data));
            end
        end
        if (reset_n && done) begin
            done_count++;
        end
    end

    // mode 0: all +1.0, mode 1: alternating +1.0/-1.0, mode 2: all 0x7FFF0000
    task automatic load_samples(input int mode);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0:       samples[i] = 32'h0001_0000;
                1:       samples[i] = (i % 2 == 0) ? 32'h0001_0000 : 32'hFFFF_0000;
                default: samples[i] = 32'h7FFF_0000;
            endcase
        end
    endtask

    task automatic push_expected(input int mode);
        wr_t e;
        int  v;
        for (int k = 0; k <= 10; k++) begin
            v = (240 - k) * 65536;
            e.addr = 11'(k);
            case (mode)
                0:       e.data = 32'(v);
                1:       e.data = (k % 2 == 0) ? 32'(v) : 32'(-v);
                default: e.data = 32'h7FFF_FFFF;
            endcase
`ifdef AUTOCORR_WNC_EN
            if (k == 0 && mode != 2) e.data = 32'h00F0_3C00;
`endif
            exp_q.push_back(e);
        end
    endtask

    // Counts negedges after the start edge until done; optional start pulse.
    task automatic wait_done(input int pulse_at, output int cyc);
        bit got;
        cyc = 0;
        got = 0;
        while (!got && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (pulse_at > 0) start = (cyc == pulse_at);
            if (done) got = 1;
        end
        if (!got) begin
            checks++;
            $display("FAIL done_timeout: no done after %0d cycles, expected done at 2608", cyc);
            cyc = -1;
        end
    endtask

    task automatic run_frame(input int mode, input int pulse_at);
        int cyc;
        int w0;
        int d0;
        load_samples(mode);
        push_expected(mode);
        w0 = write_count;
        d0 = done_count;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(pulse_at, cyc);
        check("done_latency", 64'(cyc), 64'(2608));
        check("ready_at_fin", 64'(ready), 64'(1));
        @(negedge clk);
        check("write_count", 64'(write_count - w0), 64'(11));
        check("done_count", 64'(done_count - d0), 64'(1));
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        if (pulse_at > 0) begin
            repeat (5) @(negedge clk);
            check("no_queued_frame", 64'(ready), 64'(1));
        end
    endtask

    initial begin
        int cyc;
        int w0;
        int d0;
        reset_n = 1'b0;
        start   = 1'b0;
        load_samples(0);
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_r_we", 64'(r_we), 64'(0));
        check("rst_addr", 64'({s_rsel0, s_rsel1, r_wsel}), 64'(0));
        check("rst_r_w", 64'(r_w), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(0, -1);   // all ones
        run_frame(1, -1);   // alternating sign
        run_frame(2, -1);   // saturation
        run_frame(0, 100);  // start pulse mid-frame is ignored

        // Reset mid-frame: abort, then a clean frame.
        load_samples(0);
        push_expected(0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (500) @(negedge clk);
        check("busy_before_abort", 64'(ready), 64'(0));
        reset_n = 1'b0;
        #1;
        check("abort_ready", 64'(ready), 64'(1));
        check("abort_r_we", 64'(r_we), 64'(0));
        @(negedge clk);
        check("abort_ready_hold", 64'(ready), 64'(1));
        check("abort_r_we_hold", 64'(r_we), 64'(0));
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        run_frame(0, -1);

        // start held high through FIN restarts from the first IDLE cycle.
        load_samples(0);
        push_expected(0);
        push_expected(0);
        w0 = write_count;
        d0 = done_count;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(-1, cyc);
        check("held_latency1", 64'(cyc), 64'(2608));
        @(negedge clk);
        check("held_idle_ready", 64'(ready), 64'(1));
        check("held_idle_done", 64'(done), 64'(0));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("held_restarted", 64'(ready), 64'(0));
        wait_done(-1, cyc);
        check("held_latency2", 64'(cyc), 64'(2607));
        @(negedge clk);
        check("held_write_count", 64'(write_count - w0), 64'(22));
        check("held_done_count", 64'(done_count - d0), 64'(2));
        check("held_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
